// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
package rr_mux_arbiter_pkg;

    // Arbiter sequencing states: waiting for a request, or streaming a grant
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } arb_state_e;

    // Number of requester lanes for a given select width
    function automatic int calc_n(input int s);
        return 32'sd1 << s;
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_if.sv
// Lane-side and consumer-side bus of the round-robin mux arbiter.
// slave = the arbiter, master = the environment driving lanes/consumer.
interface rr_mux_arbiter_if
    import rr_mux_arbiter_pkg::*;
#(
    parameter int S = 3,
    parameter int T = 8
);
    localparam int N = calc_n(S);

    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*T-1:0] req_data;
    logic [N-1:0]   req_last;
    logic           out_valid;
    logic           out_ready;
    logic [T-1:0]   out_data;
    logic           out_last;
    logic [S-1:0]   out_sel;
    logic           busy;

    modport master (
        output req_valid, req_data, req_last, out_ready,
        input  req_ready, out_valid, out_data, out_last, out_sel, busy
    );

    modport slave (
        input  req_valid, req_data, req_last, out_ready,
        output req_ready, out_valid, out_data, out_last, out_sel, busy
    );
endinterface

// File: rtl/rr_mux_arbiter_mux.sv
// Recursive 2^S-way mux: each level splits the lanes in half and picks
// between the two sub-results with the top select bit.
module rec_mux
    import rr_mux_arbiter_pkg::*;
#(
    parameter int S = 3,
    parameter int T = 8
) (
    input  logic [S-1:0]             i_ctrl,
    input  logic [calc_n(S)*T-1:0]   i_data,
    output logic [T-1:0]             o_data
);
    generate
        if (S == 1) begin : g_leaf
            assign o_data = i_ctrl[0] ? i_data[2*T-1:T] : i_data[T-1:0];
        end else begin : g_node
            localparam int HALF = calc_n(S - 1) * T;
            logic [T-1:0] w_lo;
            logic [T-1:0] w_hi;

            rec_mux #(.S(S - 1), .T(T)) u_lo (
                .i_ctrl (i_ctrl[S-2:0]),
                .i_data (i_data[HALF-1:0]),
                .o_data (w_lo)
            );

            rec_mux #(.S(S - 1), .T(T)) u_hi (
                .i_ctrl (i_ctrl[S-2:0]),
                .i_data (i_data[2*HALF-1:HALF]),
                .o_data (w_hi)
            );

            assign o_data = i_ctrl[S-1] ? w_hi : w_lo;
        end
    endgenerate
endmodule

// File: rtl/rr_mux_arbiter_pick.sv
// Round-robin picker: rotate requests so ptr sits at bit 0, take the lowest
// set bit, then rotate the index back. Purely combinational.
module rr_pick
    import rr_mux_arbiter_pkg::*;
#(
    parameter int S = 3
) (
    input  logic [calc_n(S)-1:0] i_req,
    input  logic [S-1:0]         i_ptr,
    output logic                 o_any,
    output logic [S-1:0]         o_idx
);
    localparam int N = calc_n(S);

    logic [N-1:0] w_rot;
    logic [S-1:0] w_src;
    logic [S-1:0] w_pos;
    logic         w_found;

    // Rotate, priority-encode from bit 0 upward, un-rotate
    always_comb begin
        w_rot   = '0;
        w_src   = '0;
        w_pos   = '0;
        w_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            w_src    = S'(i) + i_ptr;
            w_rot[i] = i_req[w_src];
        end
        for (int i = 0; i < N; i++) begin
            if (!w_found && w_rot[i]) begin
                w_found = 1'b1;
                w_pos   = S'(i);
            end else begin
                w_found = w_found;
            end
        end
        o_any = w_found;
        o_idx = w_pos + i_ptr;
    end
endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter/sequencer owning the select of the shared lane mux.
// Optional macro RR_MUX_ARB_LOCK_EN: hold the grant until a beat with
// req_last; otherwise every accepted beat ends the grant.
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int S = 3,
    parameter int T = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rr_mux_arbiter_if.slave      bus
);
    localparam int N = calc_n(S);

    arb_state_e   r_state;
    arb_state_e   w_state_nxt;
    logic [S-1:0] r_ptr;
    logic [S-1:0] w_ptr_nxt;
    logic [S-1:0] r_sel;
    logic [S-1:0] w_sel_nxt;
    logic         r_out_valid;
    logic [T-1:0] r_out_data;
    logic         r_out_last;

    logic         w_any;
    logic [S-1:0] w_pick;
    logic [T-1:0] w_mux_data;
    logic         w_lane_ready;
    logic [N-1:0] w_ready_vec;
    logic         w_xfer;
    logic         w_grant_end;

    rr_pick #(.S(S)) u_pick (
        .i_req (bus.req_valid),
        .i_ptr (r_ptr),
        .o_any (w_any),
        .o_idx (w_pick)
    );

    rec_mux #(.S(S), .T(T)) u_mux (
        .i_ctrl (r_sel),
        .i_data (bus.req_data),
        .o_data (w_mux_data)
    );

    // Granted lane may push when the output register is empty or draining
    always_comb begin
        w_lane_ready = 1'b0;
        w_ready_vec  = '0;
        w_xfer       = 1'b0;
        w_grant_end  = 1'b0;
        if (r_state == ST_XFER) begin
            w_lane_ready = !r_out_valid || bus.out_ready;
        end else begin
            w_lane_ready = 1'b0;
        end
        if (w_lane_ready) begin
            w_ready_vec[r_sel] = 1'b1;
        end else begin
            w_ready_vec = '0;
        end
        w_xfer = w_lane_ready && bus.req_valid[r_sel];
`ifdef RR_MUX_ARB_LOCK_EN
        w_grant_end = w_xfer && bus.req_last[r_sel];
`else
        w_grant_end = w_xfer;
`endif
    end

    // Next-state logic: arbitrate in IDLE, release the grant on its final beat
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_nxt = ST_XFER;
                    w_sel_nxt   = w_pick;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_XFER: begin
                if (w_grant_end) begin
                    w_state_nxt = ST_IDLE;
                    w_ptr_nxt   = r_sel + S'(1'b1);
                end else begin
                    w_state_nxt = ST_XFER;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Control registers: state, grant index and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_sel   <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // One-entry output register; a load wins over a drain in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_mux_data;
            r_out_last  <= bus.req_last[r_sel];
        end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

    assign bus.req_ready = w_ready_vec;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_last  = r_out_last;
    assign bus.out_sel   = r_sel;
    assign bus.busy      = (r_state == ST_XFER);
endmodule
